// File: rtl/enable_map.sv
// enable_map: run-time loadable RAM/bus enable decoder.
//
// A synchronous block-RAM table maps {active_config, rwbar, address region} to an
// entry of ENABLE_BITS enable bits (bit1 = ram, bit0 = bus, bits 2.. = aux). The
// table is filled over a valid/ready stream in index order. Configuration changes
// are held pending until phi2 (synchronised) is low, so a mapping never switches
// in the middle of a bus cycle.
//
// Ports:
//   fpga_clk, reset          system clock, synchronous active-high reset
//   address, phi2, rwbar,    CPU bus inputs (phi2 is asynchronous to fpga_clk)
//   mreq
//   configuration,           requested configuration, adopt pulse, pending flag,
//   cfg_update, cfg_pending, configuration currently in use
//   active_config
//   load_start, load_valid,  table load stream and status
//   load_data, load_ready,
//   load_done, table_valid
//   cs_ram, cs_bus, we,      decoded enables
//   aux_en
module enable_map #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned GRANULARITY_BITS = 8,
  parameter int unsigned CONFIG_BITS      = 5,
  parameter int unsigned ENABLE_BITS      = 2,
  localparam int unsigned AUX_BITS        = (ENABLE_BITS > 2) ? ENABLE_BITS - 2 : 1
) (
  input  logic                   fpga_clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   phi2,
  input  logic                   rwbar,
  input  logic                   mreq,
  input  logic [CONFIG_BITS-1:0] configuration,
  input  logic                   cfg_update,
  output logic                   cfg_pending,
  output logic [CONFIG_BITS-1:0] active_config,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [ENABLE_BITS-1:0] load_data,
  output logic                   load_ready,
  output logic                   load_done,
  output logic                   table_valid,
  output logic                   cs_ram,
  output logic                   cs_bus,
  output logic                   we,
  output logic [AUX_BITS-1:0]    aux_en
);

  localparam int unsigned REGION_BITS = ADDR_WIDTH - GRANULARITY_BITS;
  localparam int unsigned INDEX_BITS  = CONFIG_BITS + 1 + REGION_BITS;
  localparam int unsigned DEPTH       = 2 ** INDEX_BITS;
  localparam logic [INDEX_BITS:0] LAST_PTR = (INDEX_BITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {StEmpty, StLoading, StRun} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_BITS:0]    wr_ptr_q, wr_ptr_d;
  logic                   table_valid_q, table_valid_d;
  logic                   load_done_q, load_done_d;
  logic                   load_fire;

  logic [ENABLE_BITS-1:0] lut_q [DEPTH];
  logic [INDEX_BITS-1:0]  index_q;
  logic [ENABLE_BITS-1:0] entry_q;

  logic                   phi2_meta_q, phi2_s_q;
  logic [CONFIG_BITS-1:0] pending_cfg_q, active_cfg_q;
  logic                   cfg_pending_q;
  logic                   cfg_apply;

  // Low address bits only select a byte inside a region.
  logic unused_addr;
  assign unused_addr = ^address[GRANULARITY_BITS-1:0];

  // A restart in the same cycle as a beat takes priority; that beat is dropped.
  assign load_fire  = (state_q == StLoading) && load_valid && !load_start;
  assign load_ready = (state_q == StLoading);

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    table_valid_d = table_valid_q;
    load_done_d   = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (load_start) begin
          state_d  = StLoading;
          wr_ptr_d = '0;
        end
      end
      StLoading: begin
        if (load_start) begin
          wr_ptr_d = '0;
        end else if (load_valid) begin
          wr_ptr_d = wr_ptr_q + (INDEX_BITS + 1)'(1);
          if (wr_ptr_q == LAST_PTR) begin
            state_d       = StRun;
            table_valid_d = 1'b1;
            load_done_d   = 1'b1;
          end
        end
      end
      StRun: begin
        if (load_start) begin
          state_d       = StLoading;
          wr_ptr_d      = '0;
          table_valid_d = 1'b0;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q       <= StEmpty;
      wr_ptr_q      <= '0;
      table_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      table_valid_q <= table_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Table: write port from the load stream, registered read in RUN only
  // ---------------------------------------------------------------------------
  always_ff @(posedge fpga_clk) begin
    if (load_fire) begin
      lut_q[wr_ptr_q[INDEX_BITS-1:0]] <= load_data;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      index_q <= '0;
      entry_q <= '0;
    end else if (state_q == StRun) begin
      index_q <= {active_cfg_q, rwbar, address[ADDR_WIDTH-1:GRANULARITY_BITS]};
      entry_q <= lut_q[index_q];
    end
  end

  // ---------------------------------------------------------------------------
  // phi2 synchroniser and deferred configuration update
  // ---------------------------------------------------------------------------
  assign cfg_apply = cfg_pending_q && !phi2_s_q;

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      phi2_meta_q   <= 1'b0;
      phi2_s_q      <= 1'b0;
      cfg_pending_q <= 1'b0;
      pending_cfg_q <= configuration;
      active_cfg_q  <= configuration;
    end else begin
      phi2_meta_q <= phi2;
      phi2_s_q    <= phi2_meta_q;
      if (cfg_apply) begin
        active_cfg_q  <= pending_cfg_q;
        cfg_pending_q <= 1'b0;
      end
      // A new request overrides the clear above, so it stays pending.
      if (cfg_update) begin
        pending_cfg_q <= configuration;
        cfg_pending_q <= 1'b1;
      end
    end
  end

  assign cfg_pending   = cfg_pending_q;
  assign active_config = active_cfg_q;
  assign load_done     = load_done_q;
  assign table_valid   = table_valid_q;

  // ---------------------------------------------------------------------------
  // Output decode; phi2, mreq and rwbar are used live
  // ---------------------------------------------------------------------------
  always_comb begin
    we = phi2 & ~rwbar;
    if (table_valid_q) begin
      cs_ram = mreq & phi2 & entry_q[1];
      cs_bus = (phi2 & entry_q[0]) | ~mreq;
    end else begin
      // Without a valid table everything goes to the bus.
      cs_ram = 1'b0;
      cs_bus = phi2 | ~mreq;
    end
  end

  if (ENABLE_BITS > 2) begin : g_aux
    assign aux_en = table_valid_q ? ({AUX_BITS{phi2}} & entry_q[ENABLE_BITS-1:2]) : '0;
  end else begin : g_no_aux
    assign aux_en = '0;
  end

endmodule

// File: tb/tb_enable_map.sv
// Directed self-checking bench for enable_map with default parameters.
module tb_enable_map;

  localparam int DEPTH = 2 ** 14;

  logic        fpga_clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        phi2, rwbar, mreq;
  logic [4:0]  configuration;
  logic        cfg_update;
  logic        cfg_pending;
  logic [4:0]  active_config;
  logic        load_start, load_valid;
  logic [1:0]  load_data;
  logic        load_ready, load_done, table_valid;
  logic        cs_ram, cs_bus, we;
  logic [0:0]  aux_en;

  int checks = 0;
  int errors = 0;
  int writes, dones;

  always #5 fpga_clk = ~fpga_clk;

  enable_map dut (
    .fpga_clk      (fpga_clk),
    .reset         (reset),
    .address       (address),
    .phi2          (phi2),
    .rwbar         (rwbar),
    .mreq          (mreq),
    .configuration (configuration),
    .cfg_update    (cfg_update),
    .cfg_pending   (cfg_pending),
    .active_config (active_config),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .load_done     (load_done),
    .table_valid   (table_valid),
    .cs_ram        (cs_ram),
    .cs_bus        (cs_bus),
    .we            (we),
    .aux_en        (aux_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  // Streams DEPTH entries. pattern 0: entry = index[1:0]; pattern 1: entry = index[9:8].
  // gaps: drop load_valid every 3rd cycle. Returns accepted writes and load_done pulses.
  task automatic do_load(input bit gaps, input int pattern, output int wr, output int nd);
    int  cyc;
    bit  fire;
    logic [31:0] idx;
    wr  = 0;
    nd  = 0;
    cyc = 0;
    while (wr < DEPTH && cyc < 40000) begin
      idx        = wr;
      load_valid = gaps ? ((cyc % 3) != 2) : 1'b1;
      load_data  = (pattern == 0) ? idx[1:0] : idx[9:8];
      fire       = load_valid && load_ready;
      tick(1);
      if (fire) wr++;
      if (load_done) nd++;
      cyc++;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    address       = 16'h0000;
    phi2          = 1'b1;
    rwbar         = 1'b1;
    mreq          = 1'b1;
    configuration = 5'd0;
    cfg_update    = 1'b0;
    load_start    = 1'b0;
    load_valid    = 1'b0;
    load_data     = 2'b00;

    // Reset state and safe default with no table
    tick(2);
    reset = 1'b0;
    chk("rst_table_valid", table_valid, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_cfg_pending", cfg_pending, 0);
    chk("rst_active_config", active_config, 0);
    chk("empty_cs_ram", cs_ram, 0);
    chk("empty_cs_bus", cs_bus, 1);
    chk("empty_we_read", we, 0);
    rwbar = 1'b0;
    #1 chk("empty_we_write", we, 1);
    rwbar = 1'b1;

    // Full load with gaps
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    chk("load_ready_after_start", load_ready, 1);
    do_load(1'b1, 0, writes, dones);
    chk("load1_writes", writes, DEPTH);
    chk("load1_table_valid", table_valid, 1);
    chk("load1_done_pulse", load_done, 1);
    chk("load1_ready_low", load_ready, 0);
    tick(1);
    chk("load1_done_cleared", load_done, 0);
    chk("load1_done_count", dones, 1);

    // Lookup: config 0, read, region 2 -> entry 2'b10
    address = 16'h0200;
    tick(1);
    chk("lookup_lat1_cs_ram", cs_ram, 0);
    tick(1);
    chk("lookup_cs_ram", cs_ram, 1);
    chk("lookup_cs_bus", cs_bus, 0);
    chk("lookup_aux", aux_en, 0);
    mreq = 1'b0;
    #1 chk("lookup_nomreq_cs_ram", cs_ram, 0);
    chk("lookup_nomreq_cs_bus", cs_bus, 1);
    mreq = 1'b1;
    // Write, region 3 -> entry 2'b11
    rwbar   = 1'b0;
    address = 16'h0300;
    tick(2);
    chk("lookup3_cs_ram", cs_ram, 1);
    chk("lookup3_cs_bus", cs_bus, 1);
    chk("lookup3_we", we, 1);
    phi2 = 1'b0;
    #1 chk("phi2low_cs_ram", cs_ram, 0);
    chk("phi2low_cs_bus", cs_bus, 0);
    chk("phi2low_we", we, 0);
    phi2  = 1'b1;
    rwbar = 1'b1;
    tick(3);

    // Deferred configuration update, newest request wins
    configuration = 5'd5;
    cfg_update    = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    chk("cfg_pending_set", cfg_pending, 1);
    chk("cfg_active_held", active_config, 0);
    configuration = 5'd7;
    cfg_update    = 1'b1;
    tick(1);
    cfg_update    = 1'b0;
    configuration = 5'd3;
    tick(3);
    chk("cfg_still_pending", cfg_pending, 1);
    chk("cfg_active_still_0", active_config, 0);
    phi2 = 1'b0;
    tick(2);
    chk("cfg_sync_delay", active_config, 0);
    tick(1);
    chk("cfg_applied", active_config, 7);
    chk("cfg_pending_clear", cfg_pending, 0);
    phi2 = 1'b1;
    tick(2);

    // Reload request from RUN
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    chk("reload_table_valid", table_valid, 0);
    chk("reload_load_ready", load_ready, 1);
    chk("reload_cs_ram", cs_ram, 0);
    chk("reload_cs_bus", cs_bus, 1);

    // Reset after 100 entries
    load_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      load_data = 2'(i);
      tick(1);
    end
    load_valid    = 1'b0;
    configuration = 5'd3;
    reset         = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midreset_table_valid", table_valid, 0);
    chk("midreset_load_ready", load_ready, 0);
    chk("midreset_active_config", active_config, 3);

    // Fresh full load from pointer 0, entry = index[9:8]
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    do_load(1'b0, 1, writes, dones);
    chk("load2_writes", writes, DEPTH);
    chk("load2_table_valid", table_valid, 1);
    chk("load2_done_count", dones, 1);

    // config 3, read, region 7 -> index[9:8] = {1,1}
    address = 16'h0700;
    rwbar   = 1'b1;
    tick(2);
    chk("load2_rd_cs_ram", cs_ram, 1);
    chk("load2_rd_cs_bus", cs_bus, 1);
    // config 3, write -> index[9:8] = {1,0}
    rwbar = 1'b0;
    tick(2);
    chk("load2_wr_cs_ram", cs_ram, 1);
    chk("load2_wr_cs_bus", cs_bus, 0);
    chk("load2_wr_we", we, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
